// File: rtl/axi_txn_sequencer_if.sv
// Start/done/error sideband between the transaction sequencer and one AXI master traffic engine.
interface axi_txn_sequencer_if;
    logic M_AXI_INIT_AXI_TXN;
    logic M_AXI_TXN_DONE;
    logic M_AXI_ERROR;

    modport master (
        output M_AXI_INIT_AXI_TXN,
        input  M_AXI_TXN_DONE,
        input  M_AXI_ERROR
    );

    modport slave (
        input  M_AXI_INIT_AXI_TXN,
        output M_AXI_TXN_DONE,
        output M_AXI_ERROR
    );
endinterface

// File: rtl/axi_txn_sequencer.sv
// Round-robin sharing of one AXI master traffic engine between NUM_REQ requesters,
// with INIT pulse generation, DONE edge detection, error capture and a timeout watchdog.
module axi_txn_sequencer #(
    parameter int NUM_REQ           = 4,
    parameter int INIT_PULSE_CYCLES = 2,
    parameter int TIMEOUT_CYCLES    = 4096
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic                 rsp_error,
    output logic                 rsp_timeout,
    output logic                 busy,
    output logic [15:0]          txn_count,
    axi_txn_sequencer_if.master  m_axi
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CW    = IDX_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int PLS_W = $clog2(INIT_PULSE_CYCLES) + 1;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PLS_W-1:0] PLS_LAST = PLS_W'(INIT_PULSE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
    localparam logic [CW-1:0]    NUM_CW   = CW'(NUM_REQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_INIT,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [PLS_W-1:0]   pulse_q, pulse_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               err_q, err_d;
    logic               tmo_q, tmo_d;
    logic [15:0]        count_q, count_d;
    logic               done_q, done_d;
    logic               done_rise;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;

    assign done_d    = m_axi.M_AXI_TXN_DONE;
    assign done_rise = m_axi.M_AXI_TXN_DONE & ~done_q;

    // Scan requesters starting at the round-robin pointer, wrapping past the last index.
    always_comb begin
        logic [CW-1:0] cand;
        cand       = '0;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_q} + CW'(i);
            if (cand >= NUM_CW) begin
                cand = cand - NUM_CW;
            end
            if (!pick_found && req[cand[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        pulse_d = pulse_q;
        timer_d = timer_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        count_d = count_q;
        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (pick_found) begin
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    owner_d = pick_idx;
                    pulse_d = '0;
                    state_d = S_INIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_INIT: begin
                if (pulse_q == PLS_LAST) begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end else begin
                    pulse_d = pulse_q + 1'b1;
                end
            end
            // A DONE edge on the expiry cycle still counts as a normal completion.
            S_WAIT: begin
                if (done_rise) begin
                    err_d   = m_axi.M_AXI_ERROR;
                    tmo_d   = 1'b0;
                    state_d = S_RESP;
                end else if (timer_q == TMR_LAST) begin
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RESP: begin
                count_d = count_q + 16'd1;
                rr_d    = (owner_q == IDX_LAST) ? '0 : owner_q + 1'b1;
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            rr_q    <= '0;
            pulse_q <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            pulse_q <= pulse_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign grant                    = grant_q;
    assign rsp_valid                = (state_q == S_RESP) ? grant_q : '0;
    assign rsp_error                = (state_q == S_RESP) & err_q;
    assign rsp_timeout              = (state_q == S_RESP) & tmo_q;
    assign busy                     = (state_q != S_IDLE);
    assign txn_count                = count_q;
    assign m_axi.M_AXI_INIT_AXI_TXN = (state_q == S_INIT);
endmodule

// File: tb/tb_axi_txn_sequencer.sv
// Directed bench for axi_txn_sequencer: a small AXI master model drives DONE/ERROR per scenario.
module tb_axi_txn_sequencer;
    localparam int NUM_REQ           = 4;
    localparam int INIT_PULSE_CYCLES = 2;
    localparam int TIMEOUT_CYCLES    = 64;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic [3:0]  rsp_valid;
    logic        rsp_error;
    logic        rsp_timeout;
    logic        busy;
    logic [15:0] txn_count;

    int checks = 0;
    int errors = 0;

    axi_txn_sequencer_if m_if ();

    axi_txn_sequencer #(
        .NUM_REQ          (NUM_REQ),
        .INIT_PULSE_CYCLES(INIT_PULSE_CYCLES),
        .TIMEOUT_CYCLES   (TIMEOUT_CYCLES)
    ) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .req        (req),
        .grant      (grant),
        .rsp_valid  (rsp_valid),
        .rsp_error  (rsp_error),
        .rsp_timeout(rsp_timeout),
        .busy       (busy),
        .txn_count  (txn_count),
        .m_axi      (m_if)
    );

    always #5 ACLK = ~ACLK;

    // Master model: waits for INIT, clears DONE (at INIT, or at cycle drop_at after INIT falls),
    // raises DONE at cycle done_at after INIT falls (never if negative), and reports the response.
    // Cycle 1 is the first cycle with INIT low; every observation happens on the falling edge.
    task automatic drive_master(input int drop_at, input int done_at, input logic err_val,
                                output int init_wait, output int init_len, output logic [3:0] grant_init,
                                output int rsp_cycle, output logic [3:0] rsp_vec,
                                output logic rsp_err, output logic rsp_tmo);
        init_wait  = -1;
        init_len   = 0;
        grant_init = '0;
        rsp_cycle  = -1;
        rsp_vec    = '0;
        rsp_err    = 1'b0;
        rsp_tmo    = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge ACLK);
            if (m_if.M_AXI_INIT_AXI_TXN === 1'b1) begin
                init_wait = c;
                break;
            end
        end
        if (init_wait < 0) return;
        grant_init = grant;
        if (drop_at == 0) begin
            m_if.M_AXI_TXN_DONE = 1'b0;
            m_if.M_AXI_ERROR    = 1'b0;
        end
        init_len = 1;
        while (init_len < 20) begin
            @(negedge ACLK);
            if (m_if.M_AXI_INIT_AXI_TXN !== 1'b1) break;
            init_len++;
        end
        for (int n = 1; n <= 200; n++) begin
            if (n > 1) @(negedge ACLK);
            if (rsp_valid !== 4'b0000) begin
                rsp_cycle = n;
                rsp_vec   = rsp_valid;
                rsp_err   = rsp_error;
                rsp_tmo   = rsp_timeout;
                break;
            end
            if (n == drop_at) begin
                m_if.M_AXI_TXN_DONE = 1'b0;
                m_if.M_AXI_ERROR    = 1'b0;
            end
            if (n == done_at) begin
                m_if.M_AXI_TXN_DONE = 1'b1;
                m_if.M_AXI_ERROR    = err_val;
            end
        end
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        req = 4'b0000;
        m_if.M_AXI_TXN_DONE = 1'b0;
        m_if.M_AXI_ERROR    = 1'b0;
        repeat (3) @(negedge ACLK);
        checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL reset_grant: got %b expected 0000", grant); end
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
        checks++; if (rsp_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_error: got %b expected 0", rsp_error); end
        checks++; if (rsp_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_timeout: got %b expected 0", rsp_timeout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (m_if.M_AXI_INIT_AXI_TXN !== 1'b0) begin errors++; $display("[TB] FAIL reset_init: got %b expected 0", m_if.M_AXI_INIT_AXI_TXN); end
        checks++; if (txn_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_txn_count: got %0d expected 0", txn_count); end
        ARESET = 1'b0;
        @(negedge ACLK);
    endtask

    task automatic test_single();
        int iw, il, rc;
        logic [3:0] gi, rv;
        logic re, rt;
        req = 4'b0001;
        drive_master(0, 18, 1'b0, iw, il, gi, rc, rv, re, rt);
        req = 4'b0000;
        checks++; if (iw !== 2) begin errors++; $display("[TB] FAIL single_init_latency: got %0d expected 2", iw); end
        checks++; if (il !== 2) begin errors++; $display("[TB] FAIL single_init_len: got %0d expected 2", il); end
        checks++; if (gi !== 4'b0001) begin errors++; $display("[TB] FAIL single_grant: got %b expected 0001", gi); end
        checks++; if (rc !== 19) begin errors++; $display("[TB] FAIL single_rsp_cycle: got %0d expected 19", rc); end
        checks++; if (rv !== 4'b0001) begin errors++; $display("[TB] FAIL single_rsp_valid: got %b expected 0001", rv); end
        checks++; if (re !== 1'b0) begin errors++; $display("[TB] FAIL single_rsp_error: got %b expected 0", re); end
        checks++; if (rt !== 1'b0) begin errors++; $display("[TB] FAIL single_rsp_timeout: got %b expected 0", rt); end
        @(negedge ACLK);
        checks++; if (txn_count !== 16'd1) begin errors++; $display("[TB] FAIL single_txn_count: got %0d expected 1", txn_count); end
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL single_rsp_one_cycle: got %b expected 0000", rsp_valid); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL single_grant_cleared: got %b expected 0000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_txn();
        bit seen_init = 0;
        bit in_wait = 0;
        int extra = 0;
        req = 4'b0100;
        for (int c = 0; c < 30; c++) begin
            @(negedge ACLK);
            if (m_if.M_AXI_INIT_AXI_TXN === 1'b1) seen_init = 1;
            else if (seen_init) begin
                in_wait = 1;
                break;
            end
        end
        checks++; if (in_wait !== 1'b1) begin errors++; $display("[TB] FAIL midreset_reach_wait: got %b expected 1", in_wait); end
        checks++; if (grant !== 4'b0100) begin errors++; $display("[TB] FAIL midreset_grant: got %b expected 0100", grant); end
        repeat (3) @(negedge ACLK);
        ARESET = 1'b1;
        req = 4'b0000;
        @(negedge ACLK);
        ARESET = 1'b0;
        checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL midreset_grant_cleared: got %b expected 0000", grant); end
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL midreset_rsp_valid: got %b expected 0000", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
        checks++; if (m_if.M_AXI_INIT_AXI_TXN !== 1'b0) begin errors++; $display("[TB] FAIL midreset_init: got %b expected 0", m_if.M_AXI_INIT_AXI_TXN); end
        checks++; if (txn_count !== 16'd0) begin errors++; $display("[TB] FAIL midreset_txn_count: got %0d expected 0", txn_count); end
        m_if.M_AXI_TXN_DONE = 1'b1;
        m_if.M_AXI_ERROR    = 1'b1;
        repeat (10) begin
            @(negedge ACLK);
            if (rsp_valid !== 4'b0000) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL midreset_no_response: got %0d pulses expected 0", extra); end
    endtask

    task automatic test_round_robin();
        int iw, il, rc;
        logic [3:0] gi, rv, exp_vec, prev;
        logic re, rt;
        prev = 4'b0000;
        req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            drive_master(0, 3 + k, 1'b0, iw, il, gi, rc, rv, re, rt);
            if (k == 5) req = 4'b0000;
            exp_vec = 4'b0001 << (k % 4);
            checks++; if (rv !== exp_vec) begin errors++; $display("[TB] FAIL rr_owner_%0d: got %b expected %b", k, rv, exp_vec); end
            checks++; if (gi !== exp_vec) begin errors++; $display("[TB] FAIL rr_grant_%0d: got %b expected %b", k, gi, exp_vec); end
            checks++; if (rc !== 4 + k) begin errors++; $display("[TB] FAIL rr_rsp_cycle_%0d: got %0d expected %0d", k, rc, 4 + k); end
            if (k > 0) begin
                checks++; if (rv === prev) begin errors++; $display("[TB] FAIL rr_repeat_%0d: got %b same as previous owner", k, rv); end
            end
            prev = rv;
        end
        @(negedge ACLK);
        checks++; if (txn_count !== 16'd6) begin errors++; $display("[TB] FAIL rr_txn_count: got %0d expected 6", txn_count); end
    endtask

    task automatic test_timeout();
        int iw, il, rc;
        logic [3:0] gi, rv;
        logic re, rt;
        req = 4'b0001;
        drive_master(0, -1, 1'b0, iw, il, gi, rc, rv, re, rt);
        req = 4'b0000;
        checks++; if (rc !== 65) begin errors++; $display("[TB] FAIL timeout_rsp_cycle: got %0d expected 65", rc); end
        checks++; if (rv !== 4'b0001) begin errors++; $display("[TB] FAIL timeout_rsp_valid: got %b expected 0001", rv); end
        checks++; if (re !== 1'b1) begin errors++; $display("[TB] FAIL timeout_rsp_error: got %b expected 1", re); end
        checks++; if (rt !== 1'b1) begin errors++; $display("[TB] FAIL timeout_rsp_timeout: got %b expected 1", rt); end
        @(negedge ACLK);
        checks++; if (txn_count !== 16'd7) begin errors++; $display("[TB] FAIL timeout_txn_count: got %0d expected 7", txn_count); end
        checks++; if (rsp_timeout !== 1'b0) begin errors++; $display("[TB] FAIL timeout_flag_cleared: got %b expected 0", rsp_timeout); end
        req = 4'b0010;
        drive_master(0, 5, 1'b0, iw, il, gi, rc, rv, re, rt);
        req = 4'b0000;
        checks++; if (rc !== 6) begin errors++; $display("[TB] FAIL after_timeout_rsp_cycle: got %0d expected 6", rc); end
        checks++; if (rv !== 4'b0010) begin errors++; $display("[TB] FAIL after_timeout_rsp_valid: got %b expected 0010", rv); end
        checks++; if (re !== 1'b0) begin errors++; $display("[TB] FAIL after_timeout_rsp_error: got %b expected 0", re); end
        checks++; if (rt !== 1'b0) begin errors++; $display("[TB] FAIL after_timeout_rsp_timeout: got %b expected 0", rt); end
        @(negedge ACLK);
        checks++; if (txn_count !== 16'd8) begin errors++; $display("[TB] FAIL after_timeout_txn_count: got %0d expected 8", txn_count); end
    endtask

    task automatic test_stale_done();
        int iw, il, rc;
        int extra = 0;
        logic [3:0] gi, rv;
        logic re, rt;
        m_if.M_AXI_TXN_DONE = 1'b1;
        m_if.M_AXI_ERROR    = 1'b0;
        req = 4'b0100;
        drive_master(1, 5, 1'b1, iw, il, gi, rc, rv, re, rt);
        req = 4'b0000;
        checks++; if (rc !== 6) begin errors++; $display("[TB] FAIL stale_rsp_cycle: got %0d expected 6", rc); end
        checks++; if (rv !== 4'b0100) begin errors++; $display("[TB] FAIL stale_rsp_valid: got %b expected 0100", rv); end
        checks++; if (re !== 1'b1) begin errors++; $display("[TB] FAIL stale_rsp_error: got %b expected 1", re); end
        checks++; if (rt !== 1'b0) begin errors++; $display("[TB] FAIL stale_rsp_timeout: got %b expected 0", rt); end
        repeat (8) begin
            @(negedge ACLK);
            if (rsp_valid !== 4'b0000) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL stale_single_response: got %0d extra pulses expected 0", extra); end
        checks++; if (txn_count !== 16'd9) begin errors++; $display("[TB] FAIL stale_txn_count: got %0d expected 9", txn_count); end
    endtask

    task automatic test_done_on_expiry();
        int iw, il, rc;
        logic [3:0] gi, rv;
        logic re, rt;
        req = 4'b1000;
        drive_master(0, 64, 1'b0, iw, il, gi, rc, rv, re, rt);
        req = 4'b0000;
        checks++; if (rc !== 65) begin errors++; $display("[TB] FAIL expiry_rsp_cycle: got %0d expected 65", rc); end
        checks++; if (rv !== 4'b1000) begin errors++; $display("[TB] FAIL expiry_rsp_valid: got %b expected 1000", rv); end
        checks++; if (re !== 1'b0) begin errors++; $display("[TB] FAIL expiry_rsp_error: got %b expected 0", re); end
        checks++; if (rt !== 1'b0) begin errors++; $display("[TB] FAIL expiry_rsp_timeout: got %b expected 0", rt); end
        @(negedge ACLK);
        checks++; if (txn_count !== 16'd10) begin errors++; $display("[TB] FAIL expiry_txn_count: got %0d expected 10", txn_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_mid_txn();
        test_round_robin();
        test_timeout();
        test_stale_done();
        test_done_on_expiry();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
